dz_rx_scanner: RTL and testbench

Receive scanner for the DZ-11 multiplexer. It polls the eight per-line UART receivers round-robin and pushes each received character into the DZ-11 receive SILO as one 11-bit entry. It clears the UART's receive-full flag once the character is taken. It sits between the eight UART receivers and the SILO FIFO, and runs on the same clock-enable tick as the SILO.

---
 rtl/dz_rx_scanner.sv | 84 ++++++++
 tb/tb_dz_rx_scanner.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dz_rx_scanner.sv
// DZ-11 receive scanner: polls eight UART receivers round-robin and pushes
// each received character into the receive SILO as {line, char}.
module dz_rx_scanner (
    input  logic        clk,
    input  logic        rst,
    input  logic        clken,
    input  logic        clr,
    input  logic        mse,
    input  logic [7:0]  rxena,
    input  logic [7:0]  rxfull,
    input  logic [63:0] rxdata,
    output logic [7:0]  rxclr,
    output logic [10:0] fifo_din,
    output logic        fifo_wr,
    output logic [7:0]  lost
);

    localparam logic [1:0] ST_SCAN = 2'd0;
    localparam logic [1:0] ST_PUSH = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0] state;
    logic [2:0] ptr;
    logic [1:0] hold_cnt;
    logic [7:0] cur_char;

    assign cur_char = rxdata[{ptr, 3'b000} +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_SCAN;
            ptr      <= '0;
            hold_cnt <= '0;
            rxclr    <= '0;
            fifo_din <= '0;
            fifo_wr  <= 1'b0;
            lost     <= '0;
        end else if (clr) begin
            state    <= ST_SCAN;
            ptr      <= '0;
            hold_cnt <= '0;
            rxclr    <= '0;
            fifo_wr  <= 1'b0;
            lost     <= '0;
        end else if (clken) begin
            case (state)
                ST_SCAN: begin
                    if (mse) begin
                        if (rxfull[ptr]) begin
                            rxclr      <= '0;
                            rxclr[ptr] <= 1'b1;
                            if (rxena[ptr]) begin
                                fifo_din <= {ptr, cur_char};
                                fifo_wr  <= 1'b1;
                            end else if (lost != '1) begin
                                lost <= lost + 8'd1;
                            end
                            state <= ST_PUSH;
                        end else begin
                            ptr <= ptr + 3'd1;
                        end
                    end
                end
                ST_PUSH: begin
                    fifo_wr  <= 1'b0;
                    rxclr    <= '0;
                    hold_cnt <= '0;
                    state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Fourth HOLD tick leaves regardless, so a stuck UART cannot starve the rest
                    if (!rxfull[ptr] || hold_cnt == 2'd3) begin
                        ptr   <= ptr + 3'd1;
                        state <= ST_SCAN;
                    end else begin
                        hold_cnt <= hold_cnt + 2'd1;
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_dz_rx_scanner.sv
// Self-checking bench for dz_rx_scanner: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a tick-age reference model.
module tb_dz_rx_scanner;

    logic        clk;
    logic        rst;
    logic        clken;
    logic        clr;
    logic        mse;
    logic [7:0]  rxena;
    logic [7:0]  full_r;
    logic [63:0] rxdata;
    logic [7:0]  rxclr;
    logic [10:0] fifo_din;
    logic        fifo_wr;
    logic [7:0]  lost;

    dz_rx_scanner dut (
        .clk      (clk),
        .rst      (rst),
        .clken    (clken),
        .clr      (clr),
        .mse      (mse),
        .rxena    (rxena),
        .rxfull   (full_r),
        .rxdata   (rxdata),
        .rxclr    (rxclr),
        .fifo_din (fifo_din),
        .fifo_wr  (fifo_wr),
        .lost     (lost)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: m_age counts ticks since a line was taken (0 = scanning).
    int          m_age;
    int          m_ptr;
    logic        m_wr;
    logic [7:0]  m_rxclr;
    logic [10:0] m_din;
    int          m_lost;

    // UART side: pending acknowledges, lines that never drop rxfull, slow-drop mode.
    logic [7:0] pend;
    logic [7:0] stuck;
    bit         uart_slow;

    int   tick_no;
    int   push_t[$];
    logic [10:0] push_din[$];
    int   clr2_pulses;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, got, exp, tick_no);
        end
    endtask

    task automatic model_reset(input bit keep_din);
        m_age   = 0;
        m_ptr   = 0;
        m_wr    = 1'b0;
        m_rxclr = '0;
        m_lost  = 0;
        if (!keep_din) m_din = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(1'b0);
        else if (clr) model_reset(1'b1);
        else if (clken) begin
            if (m_age == 0) begin
                if (mse && full_r[m_ptr]) begin
                    m_rxclr = 8'd1 << m_ptr;
                    if (rxena[m_ptr]) begin
                        m_din = {3'(m_ptr), rxdata[m_ptr*8 +: 8]};
                        m_wr  = 1'b1;
                    end else if (m_lost < 255) begin
                        m_lost++;
                    end
                    m_age = 1;
                end else if (mse) begin
                    m_ptr = (m_ptr + 1) % 8;
                end
            end else if (m_age == 1) begin
                m_wr    = 1'b0;
                m_rxclr = '0;
                m_age   = 2;
            end else if (!full_r[m_ptr] || m_age == 5) begin
                m_ptr = (m_ptr + 1) % 8;
                m_age = 0;
            end else begin
                m_age++;
            end
        end
        #1;
        tick_no++;
        chk("fifo_wr", 32'(fifo_wr), 32'(m_wr));
        chk("rxclr", 32'(rxclr), 32'(m_rxclr));
        chk("lost", 32'(lost), 32'(m_lost));
        chk("fifo_din", 32'(fifo_din), 32'(m_din));
        if (fifo_wr) begin
            push_t.push_back(tick_no);
            push_din.push_back(fifo_din);
        end
        if (rxclr[2]) clr2_pulses++;
        for (int n = 0; n < 8; n++) begin
            if (m_rxclr[n]) pend[n] = 1'b1;
            if (pend[n] && !stuck[n] && (!uart_slow || $urandom_range(0, 2) == 0)) begin
                full_r[n] = 1'b0;
                pend[n]   = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic load_char(input int n, input logic [7:0] c);
        rxdata[n*8 +: 8] = c;
        full_r[n]        = 1'b1;
    endtask

    task automatic clear_logs();
        push_t.delete();
        push_din.delete();
        clr2_pulses = 0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int  wr_seen;
        int  rxclr_seen;
        int  budget;
        bit  found;

        tick_no   = 0;
        rst       = 1'b1;
        clken     = 1'b0;
        clr       = 1'b0;
        mse       = 1'b0;
        rxena     = 8'hFF;
        full_r    = '0;
        rxdata    = '0;
        pend      = '0;
        stuck     = '0;
        uart_slow = 1'b0;
        model_reset(1'b0);
        clear_logs();

        // Reset state
        @(negedge clk);
        tick();
        tick();
        chk("rst_wr", 32'(fifo_wr), 32'd0);
        chk("rst_rxclr", 32'(rxclr), 32'd0);
        chk("rst_lost", 32'(lost), 32'd0);
        chk("rst_din", 32'(fifo_din), 32'd0);
        rst   = 1'b0;
        clken = 1'b1;
        mse   = 1'b1;

        // Single character on line 5
        clear_logs();
        load_char(5, 8'h41);
        wr_seen    = 0;
        rxclr_seen = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (fifo_wr) wr_seen++;
            if (rxclr == 8'h20) rxclr_seen++;
        end
        chk("single_pushes", 32'(wr_seen), 32'd1);
        chk("single_rxclr", 32'(rxclr_seen), 32'd1);
        if (push_din.size() > 0) chk("single_din", 32'(push_din[0]), 32'(11'b101_01000001));
        else chk("single_din_missing", 32'd0, 32'd1);

        // Disabled line 2: discard, then saturate lost
        do_clr();
        clear_logs();
        rxena   = 8'hFB;
        wr_seen = 0;
        budget  = 0;
        found   = 1'b0;
        while (clr2_pulses < 300 && budget < 6000) begin
            if (m_age == 0 && !full_r[2] && !pend[2]) load_char(2, 8'($urandom));
            tick();
            budget++;
            if (fifo_wr) wr_seen++;
            if (clr2_pulses == 1 && !found) begin
                found = 1'b1;
                chk("lost_first", 32'(lost), 32'd1);
            end
        end
        chk("dis_pulses", 32'(clr2_pulses), 32'd300);
        chk("dis_no_wr", 32'(wr_seen), 32'd0);
        chk("lost_sat", 32'(lost), 32'd255);
        for (int i = 0; i < 8; i++) tick();
        full_r = '0;
        pend   = '0;
        rxena  = 8'hFF;

        // clr with clken low still clears on the next clk
        clken = 1'b0;
        do_clr();
        chk("clr_gated_lost", 32'(lost), 32'd0);
        clken = 1'b1;

        // mse low: lines full but nothing is serviced
        clear_logs();
        mse = 1'b0;
        for (int n = 0; n < 8; n++) load_char(n, 8'h60 + 8'(n));
        rxclr_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rxclr != 0) rxclr_seen++;
        end
        chk("mse0_pushes", 32'(push_t.size()), 32'd0);
        chk("mse0_rxclr", 32'(rxclr_seen), 32'd0);
        mse = 1'b1;
        tick();
        chk("mse1_wr", 32'(fifo_wr), 32'd1);
        chk("mse1_line", 32'(fifo_din), 32'({3'd0, 8'h60}));
        for (int i = 0; i < 30; i++) tick();

        // Round-robin over eight full lines
        do_clr();
        clear_logs();
        for (int n = 0; n < 8; n++) load_char(n, 8'h30 + 8'(n));
        for (int i = 0; i < 30; i++) tick();
        chk("rr_count", 32'(push_t.size()), 32'd8);
        if (push_t.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("rr_din", 32'(push_din[k]), 32'({3'(k), 8'h30 + 8'(k)}));
                if (k > 0) chk("rr_gap", 32'(push_t[k] - push_t[k-1]), 32'd3);
            end
        end

        // Stuck UART on line 3, line 4 waiting behind it
        do_clr();
        clear_logs();
        stuck = 8'h08;
        load_char(3, 8'hA3);
        load_char(4, 8'hB4);
        for (int i = 0; i < 40; i++) tick();
        if (push_t.size() >= 3) begin
            chk("stuck_first", 32'(push_din[0]), 32'({3'd3, 8'hA3}));
            chk("stuck_next", 32'(push_din[1]), 32'({3'd4, 8'hB4}));
            chk("stuck_gap", 32'(push_t[1] - push_t[0]), 32'd6);
            chk("stuck_again", 32'(push_din[2]), 32'({3'd3, 8'hA3}));
        end else begin
            chk("stuck_count", 32'(push_t.size()), 32'd3);
        end
        stuck     = '0;
        full_r[3] = 1'b0;
        pend      = '0;
        for (int i = 0; i < 8; i++) tick();

        // Asynchronous reset while a push is in flight
        do_clr();
        load_char(1, 8'h5A);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (fifo_wr) found = 1'b1;
        end
        chk("rst_push_found", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_wr", 32'(fifo_wr), 32'd0);
        chk("arst_rxclr", 32'(rxclr), 32'd0);
        chk("arst_lost", 32'(lost), 32'd0);
        chk("arst_din", 32'(fifo_din), 32'd0);
        model_reset(1'b0);
        full_r = '0;
        pend   = '0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        load_char(0, 8'h11);
        load_char(7, 8'h77);
        tick();
        chk("post_rst_ptr0", 32'(fifo_din), 32'({3'd0, 8'h11}));
        for (int i = 0; i < 20; i++) tick();

        // Randomized traffic with a slow-acknowledging UART
        uart_slow = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            clken = ($urandom_range(0, 3) != 0);
            mse   = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) rxena = 8'($urandom);
            for (int n = 0; n < 8; n++) begin
                if (!full_r[n] && !pend[n] && $urandom_range(0, 9) == 0) load_char(n, 8'($urandom));
                else if ($urandom_range(0, 7) == 0) rxdata[n*8 +: 8] = 8'($urandom);
            end
            tick();
        end
        clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
